// File: rtl/write_back_stage_pkg.sv
// Shared processor constants used by the write-back stage and its helpers.
package write_back_stage_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int R0_ADDR    = 0;
    localparam int RETIRE_W   = 16;
endpackage

// File: rtl/write_back_stage_retire_counter.sv
// Free-running retire counter: synchronous clear, increments on enable, wraps at all-ones.
module retire_counter
    import write_back_stage_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [RETIRE_W-1:0] count
);
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/write_back_stage.sv
// WB pipeline register driving the register-file write port, forwarding path and retire count.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int DATA_W     = write_back_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = write_back_stage_pkg::REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  validMEM,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic [DATA_W-1:0]     outputDataReadMEM,
    input  logic [DATA_W-1:0]     outputMemULA,
    input  logic [REG_ADDR_W-1:0] outputRegDst,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  writeRegEnable,
    output logic [REG_ADDR_W-1:0] writeRegAddr,
    output logic [DATA_W-1:0]     writeRegData,
    output logic                  fwdValid,
    output logic [15:0]           retiredCount
);
    logic                  valid, regWrite, memToReg, notWritten;
    logic [DATA_W-1:0]     aluData, memData;
    logic [REG_ADDR_W-1:0] regDst;
    logic                  load, liveWrite;

    assign load = !stall && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= 1'b0;
            regWrite   <= 1'b0;
            memToReg   <= 1'b0;
            notWritten <= 1'b0;
            aluData    <= '0;
            memData    <= '0;
            regDst     <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            notWritten <= 1'b0;
        end else if (stall) begin
            // Held entry keeps forwarding but must not write a second time.
            notWritten <= 1'b0;
        end else begin
            valid      <= validMEM;
            regWrite   <= RegWrite;
            memToReg   <= MemtoReg;
            notWritten <= validMEM;
            aluData    <= outputMemULA;
            memData    <= outputDataReadMEM;
            regDst     <= outputRegDst;
        end
    end

    assign liveWrite      = valid && regWrite && (regDst != REG_ADDR_W'(R0_ADDR));
    assign fwdValid       = liveWrite;
    assign writeRegEnable = liveWrite && notWritten;
    assign writeRegAddr   = valid ? regDst : '0;
    assign writeRegData   = valid ? (memToReg ? memData : aluData) : '0;

    // Counting at the load edge makes the count visible in the entry's first WB cycle.
    retire_counter u_retire (
        .clock  (clock),
        .reset  (reset),
        .enable (load && validMEM),
        .count  (retiredCount)
    );
endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboarded bench: expected writes are queued at issue, a negedge monitor checks every write strobe.
module tb_write_back_stage;
    logic        clock = 1'b0;
    logic        reset, validMEM, RegWrite, MemtoReg, stall, flush;
    logic [15:0] outputDataReadMEM, outputMemULA;
    logic [2:0]  outputRegDst;
    logic        writeRegEnable, fwdValid;
    logic [2:0]  writeRegAddr;
    logic [15:0] writeRegData, retiredCount;

    int errors = 0;
    int checks = 0;
    logic [18:0] expq[$];

    write_back_stage dut (
        .clock(clock), .reset(reset), .validMEM(validMEM), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .outputDataReadMEM(outputDataReadMEM),
        .outputMemULA(outputMemULA), .outputRegDst(outputRegDst), .stall(stall),
        .flush(flush), .writeRegEnable(writeRegEnable), .writeRegAddr(writeRegAddr),
        .writeRegData(writeRegData), .fwdValid(fwdValid), .retiredCount(retiredCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vm, input logic rw, input logic m2r,
                         input logic [15:0] mem, input logic [15:0] alu,
                         input logic [2:0] dst, input logic st, input logic fl);
        validMEM = vm; RegWrite = rw; MemtoReg = m2r;
        outputDataReadMEM = mem; outputMemULA = alu; outputRegDst = dst;
        stall = st; flush = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && writeRegEnable) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h, none expected",
                         writeRegAddr, writeRegData);
            end else begin
                logic [18:0] e;
                e = expq.pop_front();
                chk("write_port", {13'd0, writeRegAddr, writeRegData}, {13'd0, e});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
        tick(); tick();
        chk("reset_en",   {31'd0, writeRegEnable}, 32'd0);
        chk("reset_fwd",  {31'd0, fwdValid}, 32'd0);
        chk("reset_addr", {29'd0, writeRegAddr}, 32'd0);
        chk("reset_data", {16'd0, writeRegData}, 32'd0);
        chk("reset_cnt",  {16'd0, retiredCount}, 32'd0);
        reset = 1'b0;

        // Load from memory into R3
        expq.push_back({3'd3, 16'h1234});
        drive(1, 1, 1, 16'h1234, 16'h0040, 3'd3, 0, 0);
        tick();
        chk("load_en",  {31'd0, writeRegEnable}, 32'd1);
        chk("load_cnt", {16'd0, retiredCount}, 32'd1);

        // ALU result into R5, single-cycle pulse
        expq.push_back({3'd5, 16'hBEEF});
        drive(1, 1, 0, 16'h7777, 16'hBEEF, 3'd5, 0, 0);
        tick();
        chk("alu_data", {16'd0, writeRegData}, 32'hBEEF);
        drive(0, 1, 0, 16'h0, 16'h1111, 3'd1, 0, 0);
        tick();
        chk("alu_pulse_end", {31'd0, writeRegEnable}, 32'd0);
        chk("bubble_fwd",    {31'd0, fwdValid}, 32'd0);
        chk("bubble_cnt",    {16'd0, retiredCount}, 32'd2);

        // Write aimed at R0
        drive(1, 1, 0, 16'h0, 16'h5A5A, 3'd0, 0, 0);
        tick();
        chk("r0_en",  {31'd0, writeRegEnable}, 32'd0);
        chk("r0_fwd", {31'd0, fwdValid}, 32'd0);
        chk("r0_cnt", {16'd0, retiredCount}, 32'd3);

        // R2 write held by a 3-cycle stall
        expq.push_back({3'd2, 16'h0ABC});
        drive(1, 1, 0, 16'h0, 16'h0ABC, 3'd2, 0, 0);
        tick();
        chk("stall_c1_en",  {31'd0, writeRegEnable}, 32'd1);
        chk("stall_c1_fwd", {31'd0, fwdValid}, 32'd1);
        drive(1, 1, 0, 16'h0, 16'hDEAD, 3'd6, 1, 0);
        for (int c = 2; c <= 3; c++) begin
            tick();
            chk("stall_en",   {31'd0, writeRegEnable}, 32'd0);
            chk("stall_fwd",  {31'd0, fwdValid}, 32'd1);
            chk("stall_addr", {29'd0, writeRegAddr}, 32'd2);
            chk("stall_data", {16'd0, writeRegData}, 32'h0ABC);
        end
        chk("stall_cnt", {16'd0, retiredCount}, 32'd4);

        // Entry in WB survives a flush; flush beats stall for the incoming one
        expq.push_back({3'd4, 16'h0F0F});
        drive(1, 1, 1, 16'h0F0F, 16'h0, 3'd4, 0, 0);
        tick();
        drive(1, 1, 0, 16'h0, 16'h3333, 3'd6, 1, 1);
        tick();
        chk("flush_en",   {31'd0, writeRegEnable}, 32'd0);
        chk("flush_fwd",  {31'd0, fwdValid}, 32'd0);
        chk("flush_addr", {29'd0, writeRegAddr}, 32'd0);
        chk("flush_data", {16'd0, writeRegData}, 32'd0);
        chk("flush_cnt",  {16'd0, retiredCount}, 32'd5);

        // Non-writing retires up to the wrap point
        drive(1, 0, 0, 16'h0, 16'h0, 3'd1, 0, 0);
        repeat (65530) @(posedge clock);
        #1;
        chk("cnt_max", {16'd0, retiredCount}, 32'hFFFF);
        tick();
        chk("cnt_wrap", {16'd0, retiredCount}, 32'h0000);

        // Reset during a stall drops the held entry
        expq.push_back({3'd7, 16'h55AA});
        drive(1, 1, 1, 16'h55AA, 16'h0, 3'd7, 0, 0);
        tick();
        chk("pre_rst_cnt", {16'd0, retiredCount}, 32'd1);
        drive(1, 1, 1, 16'h1111, 16'h0, 3'd3, 1, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_stall_fwd",  {31'd0, fwdValid}, 32'd0);
        chk("rst_stall_en",   {31'd0, writeRegEnable}, 32'd0);
        chk("rst_stall_data", {16'd0, writeRegData}, 32'd0);
        chk("rst_stall_cnt",  {16'd0, retiredCount}, 32'd0);
        reset = 1'b0;
        drive(0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
        tick(); tick();
        chk("pending_writes", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath width.
REQ-002 Parameter REG_ADDR_W, default 3, register-file address width (8 registers).
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 validMEM  in  1  MEM stage presents a valid instruction this cycle.
REQ-006 RegWrite  in  1  the instruction writes the register file.
REQ-007 MemtoReg  in  1  1: write-back data from memory; 0: from the ALU result.
REQ-008 outputDataReadMEM  in  DATA_W  data-memory read data.
REQ-009 outputMemULA  in  DATA_W  ALU result forwarded by MEM.
REQ-010 outputRegDst  in  REG_ADDR_W  destination register.
REQ-011 stall  in  1  hold the WB pipeline register.
REQ-012 flush  in  1  kill the instruction entering WB.
REQ-013 writeRegEnable  out  1  register-file write strobe.
REQ-014 writeRegAddr  out  REG_ADDR_W  register-file write address.
REQ-015 writeRegData  out  DATA_W  register-file write data.
REQ-016 fwdValid  out  1  WB holds a live register-writing result for forwarding.
REQ-017 retiredCount  out  16  count of retired instructions.

Function
REQ-018 Pipeline register (valid, RegWrite, MemtoReg, ALU result, memory data, RegDst) SHALL load from MEM inputs on each rising edge when stall=0 and flush=0.
REQ-019 writeRegData SHALL be the registered memory data when registered MemtoReg=1, else the registered ALU result (combinational from the register).
REQ-020 Latency: MEM inputs sampled at edge N SHALL appear on the write port during cycle N+1.
REQ-021 writeRegEnable = valid & RegWrite & (RegDst != 0) & notWritten; R0 is never written.
REQ-022 notWritten flag SHALL be set on load and cleared after the first write cycle, so a stalled entry writes exactly once.
REQ-023 stall=1, flush=0: register contents and valid SHALL hold; writeRegEnable stays low after the first cycle.
REQ-024 flush=1 SHALL clear valid at the next edge regardless of stall (flush has priority).
REQ-025 validMEM=0 SHALL load a bubble (valid=0); bubbles never write or retire.
REQ-026 fwdValid = valid & RegWrite & (RegDst != 0), held for the whole stall; writeRegAddr/writeRegData remain valid forwarding values.
REQ-027 retiredCount SHALL increment by 1 on the first cycle of each valid entry (independent of RegWrite); it wraps 0xFFFF -> 0x0000.
REQ-028 Flush of an entry already in WB SHALL not undo its retirement or write.

Reset
REQ-029 reset=1 at an edge SHALL clear valid, RegWrite, MemtoReg, notWritten, data fields, RegDst and retiredCount to 0; reset overrides stall and flush.
REQ-030 While valid=0, writeRegEnable=0, fwdValid=0, writeRegAddr=0 and writeRegData=0.
REQ-031 Reset mid-stall SHALL discard the held entry with no write.

Structure
REQ-032 DATA_W, REG_ADDR_W and the R0 address constant SHALL live in the shared processor package.
REQ-033 The retire counter SHALL be a sub-module retire_counter (enable, synchronous reset, 16-bit wrap).

Verification
REQ-034 Load: RegWrite=1, MemtoReg=1, RegDst=3, mem=0x1234, ALU=0x0040 -> next cycle enable=1, addr=3, data=0x1234, retiredCount=1.
REQ-035 ALU op: MemtoReg=0, RegDst=5, ALU=0xBEEF -> data=0xBEEF, one-cycle enable pulse.
REQ-036 Entry to R0 with RegWrite=1 -> enable=0, fwdValid=0, retiredCount increments.
REQ-037 Stall held 3 cycles on a write to R2 -> exactly one enable pulse, fwdValid high all 3 cycles, retire +1.
REQ-038 flush with stall both high -> next cycle valid=0, no write; reset with retiredCount=0xFFFF -> 0; 0xFFFF plus one retire -> 0x0000.
